// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC register and fetch register feeding decode
// Optional early absolute jump: define EARLY_JUMP_EN.
module instruction_fetch #(
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0]  HALT_OP  = 6'b010111,
  parameter logic [5:0]  JMP_OP   = 6'b010010
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              resume,
  output logic              halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   ir_q;
  logic [ADDR_W-1:0]   pc_out_q;
  logic                ir_valid_q;
  logic                halted_q;

  logic [5:0]          opcode;
  logic                capture;
  logic                transfer;
  logic [ADDR_W-1:0]   pc_d;

  assign opcode   = instr_in[DATA_W-1 -: 6];
  // The fetch register may be refilled when empty or being drained this edge.
  assign capture  = (state_q == RUN) && (!ir_valid_q || ir_ready);
  assign transfer = ir_valid_q && ir_ready;

  // Next PC for a capturing edge: sequential, or the jmp target when early jump is built in.
  always_comb begin
    pc_d = pc_q + ADDR_W'(1);
`ifdef EARLY_JUMP_EN
    if (opcode == JMP_OP) begin
      pc_d = instr_in[ADDR_W-1:0];
    end
`endif
  end

  // Fetch FSM: redirect beats capture, capture beats halt/resume handling.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      pc_out_q   <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_target;
      ir_valid_q <= 1'b0;
      state_q    <= RUN;
      halted_q   <= 1'b0;
    end else if (capture) begin
      ir_q       <= instr_in;
      pc_out_q   <= pc_q;
      ir_valid_q <= 1'b1;
      if (opcode == HALT_OP) begin
        state_q  <= HALT;
        halted_q <= 1'b1;
        pc_q     <= pc_q + ADDR_W'(1);
      end else begin
        pc_q     <= pc_d;
      end
    end else begin
      if (transfer) begin
        ir_valid_q <= 1'b0;
      end
      if (state_q == HALT && resume) begin
        state_q  <= RUN;
        halted_q <= 1'b0;
      end
    end
  end

  assign address  = pc_q;
  assign ir_out   = ir_q;
  assign pc_out   = pc_out_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clock;
  logic        reset;
  logic [9:0]  address;
  logic [31:0] instr_in;
  logic        redirect_valid;
  logic [9:0]  redirect_target;
  logic [31:0] ir_out;
  logic [9:0]  pc_out;
  logic        ir_valid;
  logic        ir_ready;
  logic        resume;
  logic        halted;

  logic [31:0] mem [0:1023];
  int n_checks;
  int n_errors;

`ifdef EARLY_JUMP_EN
  localparam logic [9:0] AFTER_JMP = 10'd43;
`else
  localparam logic [9:0] AFTER_JMP = 10'd4;
`endif

  instruction_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .address        (address),
    .instr_in       (instr_in),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .ir_out         (ir_out),
    .pc_out         (pc_out),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .resume         (resume),
    .halted         (halted)
  );

  assign instr_in = mem[address];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic expect_word(input string tag, input logic [9:0] a);
    check({tag, ".valid"}, 32'(ir_valid), 32'd1);
    check({tag, ".pc"}, 32'(pc_out), 32'(a));
    check({tag, ".ir"}, ir_out, mem[a]);
  endtask

  task automatic redirect(input logic [9:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    tick();
    redirect_valid  = 1'b0;
    check("redir.bubble", 32'(ir_valid), 32'd0);
    check("redir.addr", 32'(address), 32'(t));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = {6'b000001, 16'h0, 10'(i)};
    mem[3]  = {6'b010010, 16'h0, 10'd43};
    mem[67] = {6'b010111, 16'h0, 10'd67};

    reset = 1'b0; ir_ready = 1'b1; redirect_valid = 1'b0;
    redirect_target = '0; resume = 1'b0;
    tick(); tick();
    check("rst.valid", 32'(ir_valid), 32'd0);
    check("rst.pc", 32'(pc_out), 32'd0);
    check("rst.ir", ir_out, 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.addr", 32'(address), 32'd0);
    reset = 1'b1;

    // sequential fetch from reset, jmp at 3
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_word("seq", 10'(i));
    end
    check("jmp.addr", 32'(address), 32'(AFTER_JMP));
    tick();
    expect_word("jmp.next", AFTER_JMP);

    // asynchronous reset mid-run
    #2 reset = 1'b0;
    #1;
    check("arst.valid", 32'(ir_valid), 32'd0);
    check("arst.pc", 32'(pc_out), 32'd0);
    check("arst.ir", ir_out, 32'd0);
    check("arst.addr", 32'(address), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    expect_word("arst.first", 10'd0);

    // backpressure at 5
    redirect(10'd5);
    tick();
    expect_word("bp.start", 10'd5);
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_word("bp.hold", 10'd5);
      check("bp.addr", 32'(address), 32'd6);
    end
    ir_ready = 1'b1;
    tick();
    expect_word("bp.rel6", 10'd6);
    tick();
    expect_word("bp.rel7", 10'd7);

    // redirect 11 -> 18
    redirect(10'd11);
    tick();
    expect_word("rd.11", 10'd11);
    redirect(10'd18);
    tick();
    expect_word("rd.18", 10'd18);

    // PC wrap
    redirect(10'd1022);
    tick(); expect_word("wrap.1022", 10'd1022);
    tick(); expect_word("wrap.1023", 10'd1023);
    tick(); expect_word("wrap.0", 10'd0);

    // redirect overrides jmp capture
    redirect(10'd2);
    tick(); expect_word("ovr.2", 10'd2);
    redirect(10'd50);
    tick(); expect_word("ovr.50", 10'd50);

    // held word discarded by redirect
    redirect(10'd10);
    tick(); expect_word("drop.10", 10'd10);
    ir_ready = 1'b0;
    tick(); expect_word("drop.hold", 10'd10);
    redirect(10'd20);
    ir_ready = 1'b1;
    tick(); expect_word("drop.20", 10'd20);

    // halt then resume
    redirect(10'd66);
    tick(); expect_word("halt.66", 10'd66);
    tick(); expect_word("halt.67", 10'd67);
    check("halt.halted", 32'(halted), 32'd1);
    check("halt.addr", 32'(address), 32'd68);
    tick();
    check("halt.xfer.valid", 32'(ir_valid), 32'd0);
    check("halt.xfer.pc", 32'(pc_out), 32'd67);
    tick();
    check("halt.stay.valid", 32'(ir_valid), 32'd0);
    check("halt.stay.halted", 32'(halted), 32'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("res.halted", 32'(halted), 32'd0);
    check("res.valid", 32'(ir_valid), 32'd0);
    tick(); expect_word("res.68", 10'd68);

    // redirect out of halt
    redirect(10'd66);
    tick(); tick(); expect_word("hr.67", 10'd67);
    tick();
    redirect(10'd4);
    check("hr.halted", 32'(halted), 32'd0);
    tick(); expect_word("hr.4", 10'd4);

    // redirect and resume on the same edge
    redirect(10'd66);
    tick(); tick(); expect_word("rr.67", 10'd67);
    tick();
    resume = 1'b1;
    redirect(10'd30);
    resume = 1'b0;
    check("rr.halted", 32'(halted), 32'd0);
    tick(); expect_word("rr.30", 10'd30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
